// File: rtl/bidin_pkg.sv
// Shared constants and FSM state type for the bit-deinterleaver SRAM access path.
package bidin_pkg;

    localparam int unsigned BIDIN_DEPTH = 146880;
    localparam int unsigned BIDIN_A_WID = 18;
    localparam int unsigned BIDIN_D_WID = 6;

    typedef enum logic {
        ARB = 1'b0,
        CLR = 1'b1
    } bidin_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (write vs read) with enable and registered last-grant pointer.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    logic last_wr_q;
    logic last_wr_d;

    // On a tie, serve whichever side was not granted last.
    always_comb begin
        gnt_wr    = 1'b0;
        gnt_rd    = 1'b0;
        last_wr_d = last_wr_q;
        if (en) begin
            if (req_wr && req_rd) begin
                gnt_rd = last_wr_q;
                gnt_wr = ~last_wr_q;
            end else begin
                gnt_wr = req_wr;
                gnt_rd = req_rd;
            end
        end
        if (gnt_wr) begin
            last_wr_d = 1'b1;
        end else if (gnt_rd) begin
            last_wr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_q <= 1'b1;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end

endmodule

// File: rtl/sram_arb_ctrl.sv
// Shares the single deinterleaver SRAM port between write and read streams,
// screens out-of-range addresses and runs a self-timed zero-fill sweep.
module sram_arb_ctrl
    import bidin_pkg::*;
#(
    parameter int unsigned DEPTH = BIDIN_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_req,
    input  logic [BIDIN_A_WID-1:0] wr_addr,
    input  logic [BIDIN_D_WID-1:0] wr_data,
    output logic                   wr_gnt,
    input  logic                   rd_req,
    input  logic [BIDIN_A_WID-1:0] rd_addr,
    output logic                   rd_gnt,
    output logic                   rd_vld,
    output logic [BIDIN_D_WID-1:0] rd_data,
    output logic                   rd_err,
    output logic                   wr_err,
    input  logic                   clr_start,
    output logic                   clr_busy,
    output logic                   clr_done,
    output logic                   sram_cen,
    output logic                   sram_wen,
    output logic [BIDIN_A_WID-1:0] sram_a,
    output logic [BIDIN_D_WID-1:0] sram_d,
    input  logic [BIDIN_D_WID-1:0] sram_q
);

    localparam int unsigned A_WID = BIDIN_A_WID;
    localparam int unsigned D_WID = BIDIN_D_WID;
    localparam logic [A_WID-1:0] DEPTH_A  = A_WID'(DEPTH);
    localparam logic [A_WID-1:0] DEPTH_M1 = A_WID'(DEPTH - 1);

    bidin_state_e     state_q, state_d;
    logic [A_WID-1:0] clr_cnt_q, clr_cnt_d;
    logic             rd_vld_q, rd_vld_d;
    logic             rd_err_q, rd_err_d;
    logic             clr_done_q, clr_done_d;

    logic             wr_oor;
    logic             rd_oor;

    assign wr_oor = (wr_addr >= DEPTH_A);
    assign rd_oor = (rd_addr >= DEPTH_A);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q == ARB),
        .req_wr (wr_req),
        .req_rd (rd_req),
        .gnt_wr (wr_gnt),
        .gnt_rd (rd_gnt)
    );

    // Next state, clear counter, read pipeline and SRAM port mux.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = 1'b0;
        rd_vld_d   = rd_gnt;
        rd_err_d   = rd_gnt & rd_oor;
        sram_cen   = 1'b1;
        sram_wen   = 1'b1;
        sram_a     = '0;
        sram_d     = '0;
        case (state_q)
            ARB: begin
                if (clr_start) begin
                    state_d   = CLR;
                    clr_cnt_d = '0;
                end
                if (wr_gnt && !wr_oor) begin
                    sram_cen = 1'b0;
                    sram_wen = 1'b0;
                    sram_a   = wr_addr;
                    sram_d   = wr_data;
                end else if (rd_gnt && !rd_oor) begin
                    sram_cen = 1'b0;
                    sram_a   = rd_addr;
                end
            end
            CLR: begin
                sram_cen = 1'b0;
                sram_wen = 1'b0;
                sram_a   = clr_cnt_q;
                if (clr_cnt_q == DEPTH_M1) begin
                    state_d    = ARB;
                    clr_done_d = 1'b1;
                    clr_cnt_d  = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + A_WID'(1);
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            clr_cnt_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_vld_q   <= rd_vld_d;
            rd_err_q   <= rd_err_d;
            clr_done_q <= clr_done_d;
        end
    end

    // SRAM output is already registered; only gate it to zero when not a good read.
    assign rd_data  = (rd_vld_q && !rd_err_q) ? sram_q : D_WID'(0);
    assign rd_vld   = rd_vld_q;
    assign rd_err   = rd_err_q;
    assign wr_err   = wr_gnt & wr_oor;
    assign clr_busy = (state_q == CLR);
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Randomized and directed bench for sram_arb_ctrl against a behavioural memory/arbitration model.
module tb_sram_arb_ctrl;

    localparam int TB_DEPTH = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req, rd_req, clr_start;
    logic [17:0] wr_addr, rd_addr;
    logic [5:0]  wr_data;
    logic        wr_gnt, rd_gnt, rd_vld, rd_err, wr_err;
    logic [5:0]  rd_data;
    logic        clr_busy, clr_done;
    logic        sram_cen, sram_wen;
    logic [17:0] sram_a;
    logic [5:0]  sram_d;
    logic [5:0]  sram_q;

    sram_arb_ctrl #(.DEPTH(TB_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .wr_err    (wr_err),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .sram_cen  (sram_cen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    always #5 clk = ~clk;

    // External single-port SRAM with registered read data.
    logic [5:0] sram_mem [TB_DEPTH];
    always @(posedge clk) begin
        if (!sram_cen && int'(sram_a) < TB_DEPTH) begin
            if (!sram_wen) sram_mem[int'(sram_a)] <= sram_d;
            else           sram_q <= sram_mem[int'(sram_a)];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [5:0] ref_mem [TB_DEPTH];
    bit         m_last_wr, m_busy, m_pv, m_pe, m_done;
    int         m_cnt;
    logic [5:0] m_pd;
    bit         g_wr, g_rd;
    logic       obs_wr, obs_rd, obs_vld, obs_err, obs_cen, obs_werr;
    logic [5:0] obs_rdata;
    int         busy_seen, done_seen;

    task automatic reset_model();
        m_last_wr = 1'b1;
        m_busy = 1'b0;
        m_pv = 1'b0;
        m_pe = 1'b0;
        m_pd = '0;
        m_done = 1'b0;
        m_cnt = 0;
    endtask

    task automatic drive_idle();
        wr_req = 0; rd_req = 0; clr_start = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wr_gnt"},   wr_gnt, 0);
        check_eq({tag, "_rd_gnt"},   rd_gnt, 0);
        check_eq({tag, "_rd_vld"},   rd_vld, 0);
        check_eq({tag, "_rd_err"},   rd_err, 0);
        check_eq({tag, "_rd_data"},  rd_data, 0);
        check_eq({tag, "_wr_err"},   wr_err, 0);
        check_eq({tag, "_clr_busy"}, clr_busy, 0);
        check_eq({tag, "_clr_done"}, clr_done, 0);
        check_eq({tag, "_cen"},      sram_cen, 1);
        check_eq({tag, "_wen"},      sram_wen, 1);
        check_eq({tag, "_a"},        sram_a, 0);
        check_eq({tag, "_d"},        sram_d, 0);
    endtask

    task automatic do_reset(input string tag);
        drive_idle();
        rst_n = 1'b0;
        reset_model();
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: check DUT against the model at negedge, then advance the model.
    task automatic cycle();
        bit wo, ro, gw, gr;
        logic        e_cen, e_wen;
        logic [17:0] e_a;
        logic [5:0]  e_d;
        @(negedge clk);
        wo = int'(wr_addr) >= TB_DEPTH;
        ro = int'(rd_addr) >= TB_DEPTH;
        gw = 0; gr = 0;
        if (!m_busy) begin
            if (wr_req && rd_req) begin
                gr = m_last_wr;
                gw = !m_last_wr;
            end else begin
                gw = wr_req;
                gr = rd_req;
            end
        end
        e_cen = 1; e_wen = 1; e_a = '0; e_d = '0;
        if (m_busy) begin
            e_cen = 0; e_wen = 0; e_a = 18'(m_cnt);
        end else if (gw && !wo) begin
            e_cen = 0; e_wen = 0; e_a = wr_addr; e_d = wr_data;
        end else if (gr && !ro) begin
            e_cen = 0; e_a = rd_addr;
        end
        obs_wr = wr_gnt; obs_rd = rd_gnt; obs_vld = rd_vld; obs_err = rd_err;
        obs_rdata = rd_data; obs_cen = sram_cen; obs_werr = wr_err;
        if (clr_busy === 1'b1) busy_seen++;
        if (clr_done === 1'b1) done_seen++;
        check_eq("wr_gnt", wr_gnt, gw);
        check_eq("rd_gnt", rd_gnt, gr);
        check_eq("wr_err", wr_err, gw && wo);
        check_eq("rd_vld", rd_vld, m_pv);
        check_eq("rd_err", rd_err, m_pe);
        check_eq("rd_data", rd_data, (m_pv && !m_pe) ? m_pd : 6'd0);
        check_eq("clr_busy", clr_busy, m_busy);
        check_eq("clr_done", clr_done, m_done);
        check_eq("sram_cen", sram_cen, e_cen);
        check_eq("sram_wen", sram_wen, e_wen);
        check_eq("sram_a", sram_a, e_a);
        check_eq("sram_d", sram_d, e_d);
        m_pv = gr;
        m_pe = gr && ro;
        m_pd = (gr && !ro) ? ref_mem[int'(rd_addr)] : 6'd0;
        if (gw && !wo) ref_mem[int'(wr_addr)] = wr_data;
        if (gw) m_last_wr = 1'b1;
        else if (gr) m_last_wr = 1'b0;
        m_done = 1'b0;
        if (m_busy) begin
            ref_mem[m_cnt] = '0;
            if (m_cnt == TB_DEPTH - 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_cnt++;
            end
        end else if (clr_start) begin
            m_busy = 1'b1;
            m_cnt = 0;
        end
        g_wr = gw;
        g_rd = gr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] rand_addr();
        int r;
        r = $urandom_range(0, 99);
        if (r < 85)      return 18'($urandom_range(0, 63));
        else if (r < 92) return 18'(TB_DEPTH - 1);
        else             return 18'($urandom_range(TB_DEPTH, 262143));
    endfunction

    initial begin
        for (int i = 0; i < TB_DEPTH; i++) begin
            sram_mem[i] = 6'($urandom);
            ref_mem[i]  = sram_mem[i];
        end
        busy_seen = 0;
        done_seen = 0;
        g_wr = 0;
        g_rd = 0;
        do_reset("rst");

        // Write then read back address 5
        wr_req = 1; wr_addr = 18'd5; wr_data = 6'h2A;
        cycle();
        check_eq("t1_wr_gnt", obs_wr, 1);
        drive_idle();
        rd_req = 1; rd_addr = 18'd5;
        cycle();
        check_eq("t1_rd_gnt", obs_rd, 1);
        drive_idle();
        cycle();
        check_eq("t1_rd_vld", obs_vld, 1);
        check_eq("t1_rd_data", obs_rdata, 6'h2A);
        check_eq("t1_rd_err", obs_err, 0);

        // Tie alternation from reset: R,W,R,W
        do_reset("rst2");
        for (int i = 0; i < 4; i++) begin
            wr_req = 1; wr_addr = 18'(10 + i); wr_data = 6'(i + 1);
            rd_req = 1; rd_addr = 18'(20 + i);
            cycle();
            check_eq($sformatf("alt%0d_rd", i), obs_rd, (i % 2 == 0) ? 1 : 0);
            check_eq($sformatf("alt%0d_wr", i), obs_wr, (i % 2 == 1) ? 1 : 0);
        end
        drive_idle();
        cycle();

        // Out-of-range read
        rd_req = 1; rd_addr = 18'd146880;
        cycle();
        check_eq("oor_rd_gnt", obs_rd, 1);
        check_eq("oor_rd_cen", obs_cen, 1);
        drive_idle();
        cycle();
        check_eq("oor_rd_vld", obs_vld, 1);
        check_eq("oor_rd_err", obs_err, 1);
        check_eq("oor_rd_data", obs_rdata, 0);

        // Out-of-range write
        wr_req = 1; wr_addr = 18'd200000; wr_data = 6'h15;
        cycle();
        check_eq("oor_wr_gnt", obs_wr, 1);
        check_eq("oor_wr_err", obs_werr, 1);
        check_eq("oor_wr_cen", obs_cen, 1);
        drive_idle();
        cycle();

        // Randomized traffic, requests held until granted
        wr_req = 0; rd_req = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!wr_req || g_wr) begin
                wr_req = 1'($urandom_range(0, 1));
                wr_addr = rand_addr();
                wr_data = 6'($urandom);
            end
            if (!rd_req || g_rd) begin
                rd_req = 1'($urandom_range(0, 1));
                rd_addr = rand_addr();
            end
            cycle();
        end
        drive_idle();
        cycle();

        // Clear sweep with a pending write; requests held through the sweep
        busy_seen = 0;
        done_seen = 0;
        wr_req = 1; wr_addr = 18'd10; wr_data = 6'h33;
        clr_start = 1;
        cycle();
        check_eq("clr_wr_gnt", obs_wr, 1);
        clr_start = 0;
        wr_addr = 18'd11; wr_data = 6'h3C;
        rd_req = 1; rd_addr = 18'd12;
        begin
            int guard;
            guard = 0;
            while (done_seen == 0 && guard < TB_DEPTH + 20) begin
                if (guard == 100) clr_start = 1;
                else clr_start = 0;
                if (g_wr) wr_req = 0;
                if (g_rd) rd_req = 0;
                cycle();
                guard++;
            end
            check_eq("clr_done_seen", done_seen, 1);
        end
        check_eq("clr_busy_len", busy_seen, TB_DEPTH);
        drive_idle();
        for (int i = 0; i < 5; i++) cycle();
        check_eq("clr_done_once", done_seen, 1);
        begin
            logic [17:0] pts [3];
            pts[0] = 18'd0;
            pts[1] = 18'(TB_DEPTH / 2 - 1);
            pts[2] = 18'(TB_DEPTH - 1);
            for (int i = 0; i < 3; i++) begin
                rd_req = 1; rd_addr = pts[i];
                cycle();
                drive_idle();
                cycle();
                check_eq($sformatf("clr_rd%0d_vld", i), obs_vld, 1);
                check_eq($sformatf("clr_rd%0d_data", i), obs_rdata, 0);
            end
        end

        // Reset in the middle of a sweep
        done_seen = 0;
        clr_start = 1;
        cycle();
        clr_start = 0;
        for (int i = 0; i < 1000; i++) cycle();
        check_eq("mid_busy_before", obs_cen, 0);
        do_reset("mid_rst");
        for (int i = 0; i < 20; i++) cycle();
        check_eq("mid_no_done", done_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arb_ctrl.md
# sram_arb_ctrl

Access controller for the 146880x6 single-port bit-deinterleaver SRAM. It shares the one SRAM port between a write requester (the incoming soft-bit stream) and a read requester (the outgoing deinterleaved stream), using round-robin arbitration. It tracks the one-cycle read latency, screens out-of-range addresses, and provides a self-timed clear sweep that zero-fills the memory. It sits between the deinterleaver address generators and the SRAM instance, which the parent module owns.

## Interface
- A_WID, 18, SRAM address width
- D_WID, 6, SRAM data width
- DEPTH, 146880, number of valid SRAM words
- CLK  in  1  single clock; all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- wr_req  in  1  write request; held until wr_gnt
- wr_addr  in  A_WID  write address
- wr_data  in  D_WID  write data
- wr_gnt  out  1  write accepted this cycle (combinational)
- rd_req  in  1  read request; held until rd_gnt
- rd_addr  in  A_WID  read address
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_vld  out  1  rd_data valid; one cycle after rd_gnt
- rd_data  out  D_WID  read data
- rd_err  out  1  qualifies rd_vld: the address was out of range
- wr_err  out  1  one-cycle pulse: a granted write was out of range
- clr_start  in  1  one-cycle pulse: start the zero-fill sweep
- clr_busy  out  1  sweep in progress
- clr_done  out  1  one-cycle pulse when the sweep finishes
- sram_cen, sram_wen  out  1  SRAM enables, active-low
- sram_a  out  A_WID  SRAM address
- sram_d  out  D_WID  SRAM write data
- sram_q  in  D_WID  SRAM read data (registered inside the SRAM)

## Operation
- FSM states: ARB and CLR. Reset state is ARB.
- ARB, one requester: it is granted in the same cycle.
- ARB, both requesting: the requester not granted last is served. The last-granted pointer resets to "write", so read wins the first tie.
- Range check: an address >= DEPTH is granted but performs no SRAM access (sram_cen stays 1).
  - Out-of-range read: rd_vld=1, rd_err=1, rd_data=0 in the next cycle.
  - Out-of-range write: wr_err pulses in the grant cycle.
  - Out-of-range grants still update the round-robin pointer.
- SRAM drive for an in-range grant:
  - Write: sram_cen=0, sram_wen=0, sram_a=wr_addr, sram_d=wr_data.
  - Read: sram_cen=0, sram_wen=1, sram_a=rd_addr.
- Idle: sram_cen=1, sram_wen=1, sram_a=0, sram_d=0.
- rd_data is sram_q when rd_vld is high and rd_err is low; otherwise 0.
- clr_start in ARB:
  - Arbitration that cycle proceeds normally.
  - CLR is entered on the next cycle, with the clear counter at 0.
- CLR:
  - No grants are issued; requesters stall.
  - One zero write per cycle to addresses 0..DEPTH-1; the counter increments by 1.
  - After the write at DEPTH-1, the FSM returns to ARB. clr_done pulses in that first ARB cycle.
  - clr_start received during CLR is ignored.
- Reset mid-sweep: the sweep aborts with no clr_done pulse; memory contents are undefined.

## Timing
- Grant-to-SRAM-edge latency: 0 cycles. Read grant to rd_vld: 1 cycle. At most one grant per cycle.
- Sweep length: exactly DEPTH=146880 cycles. clr_busy is high for exactly those cycles.
- Reset values: wr_gnt=0, rd_gnt=0, rd_vld=0, rd_err=0, rd_data=0, wr_err=0, clr_busy=0, clr_done=0, sram_cen=1, sram_wen=1, sram_a=0, sram_d=0.
- Internal reset values: RR pointer="write", clear counter=0.
- Clear counter width: A_WID; its terminal compare is against DEPTH-1.
- Back-to-back reads are allowed every cycle; rd_vld then stays high continuously.

## Structure
- Shared package `bidin_pkg` holds:
  - Constants BIDIN_DEPTH=146880, BIDIN_A_WID=18, BIDIN_D_WID=6.
  - The FSM state enum (ARB, CLR).
- Sub-module `rr_arb2`: a 2-requester round-robin arbiter with an enable input (low during CLR) and a registered last-grant pointer.
- Top-level logic: range check, SRAM mux, read-valid pipeline, clear FSM and counter.

## Test plan
- Reset, then wr_req only, addr=5, data=0x2A, followed by rd_req addr=5. Required: wr_gnt then rd_gnt; rd_vld=1 one cycle after rd_gnt with rd_data=0x2A and rd_err=0.
- wr_req and rd_req both held for 4 cycles. Required: grants alternate R,W,R,W, with the first read grant in the first cycle.
- rd_req addr=146880. Required: rd_gnt=1 and sram_cen=1; next cycle rd_vld=1, rd_err=1, rd_data=0.
- wr_req addr=200000. Required: wr_gnt=1, wr_err pulse, sram_cen=1.
- clr_start with wr_req pending. Required:
  - Write granted that cycle.
  - clr_busy high for 146880 cycles; requests held meanwhile see no grant.
  - clr_done pulses once.
  - Reads of addresses 0, 73439 and 146879 then return 0.
- RST_N asserted after 1000 sweep cycles. Required: clr_busy=0 immediately, clr_done never pulses, sram_cen=1.
